clio_pcsc_tx: RTL and testbench
===============================

// Module: clio_pcsc_tx
// PURPOSE
//  CLIO-side video timing generator and PCSC serial transmitter.
//  Runs horizontal and vertical counters from clk_25m. Once per line it sends
//  a start bit plus 7 flag bits on the single-wire pcsc signal.
//  MADAM's pcsc receiver uses these bits to realign its hcount and latch its
//  line/field flags.
//  Pairs with that receiver: bit N (1..7) lands in MADAM pcsc_reg[N].
// PARAMETERS
//  H_TOTAL       1588  clocks per line (>= 16)
//  V_TOTAL_NTSC  263   lines per field when VD=0 (>= 2)
//  V_TOTAL_PAL   313   lines per field when VD=1 (>= 2)
// PORTS
//  clk_25m      in   1   system clock
//  reset_n      in   1   async active-low reset
//  enable       in   1   run timing; low holds counters at 0 and pcsc low
//  pal_mode     in   1   VD source; takes effect at the next field boundary
//  forced_clut  in   1   FC source; sampled at each line start
//  virs_test    in   1   VR source; sampled at each line start
//  pcsc         out  1   serial start+flag stream (registered)
//  hcount       out  11  current clock within line
//  vcount       out  9   current line within field
//  field        out  1   field parity (F#)
//  line_start   out  1   1-cycle strobe, coincident with pcsc start bit
// BEHAVIOUR
//  Reset (async): all outputs 0, counters 0, field 0, latched VD=0, shifter idle.
//  enable low:
//   - hcount, vcount and field are held at 0; pcsc=0; line_start=0.
//   - VD is reloaded from pal_mode every cycle.
//  enable rise: the first cycle with enable=1 is hcount=0 of line 0.
//  Counters (while enabled):
//   - hcount increments every clock and wraps H_TOTAL-1 -> 0.
//   - On that wrap, vcount increments and wraps V_LAST -> 0.
//   - V_LAST = (VD ? V_TOTAL_PAL : V_TOTAL_NTSC) - 1.
//   - On the vcount wrap, field toggles and VD <= pal_mode.
//  Flag word, built combinationally from the current counters at hcount==0:
//   - b1 VZ = vcount==0
//   - b2 V# = vcount[0]
//   - b3 F# = field
//   - b4 FC = forced_clut
//   - b5 VR = virs_test
//   - b6 VD = latched VD
//   - b7 VL = vcount==V_LAST
//   - The word is captured into a 7-bit shift register at hcount==0.
//  Serial timing (pcsc is registered; reference point is the hcount value in
//  the cycle pcsc is driven):
//   - hcount==0: pcsc=1 (start bit), line_start=1.
//   - hcount==k, k=1..7: pcsc = flag bit k, LSB (VZ) first.
//   - hcount>=8: pcsc=0 until the next line start.
//  Receiver guarantees:
//   - pcsc is always 0 in the cycle before a start bit, so exactly one rising
//     edge is seen while the receiver index is 0.
//   - Flag-bit toggles inside cycles 1..7 are ignored by the receiver.
//  Mid-line changes to FC/VR affect only the next line. A pal_mode change
//  affects only the next field. A VL line is never lost or duplicated.
//  If enable drops mid-burst, pcsc goes to 0 on the next clock and the burst is
//  abandoned; no partial-burst state is retained.
//  Async reset mid-burst: pcsc=0 immediately.
// STRUCTURE
//  Shared package clio_video_pkg holds:
//   - PCSC flag bit indices (VZ=1..VL=7)
//   - PCSC_BURST_LEN=8
//   - default NTSC/PAL timing constants
//  MADAM's receiver uses the same package.
//  One sub-module, pcsc_shifter: load 7-bit word + start, serialise onto pcsc,
//  abort on enable low.
//  Counters and flag assembly live in clio_pcsc_tx.
// TESTING (params H_TOTAL=32, V_TOTAL_NTSC=4, V_TOTAL_PAL=5; a MADAM pcsc
// receiver model is attached)
//  1. Reset release, enable=1, pal_mode=0, fc=0, vr=0:
//     - line 0 pcsc cycles 0..7 = 1,1,0,0,0,0,0,0, then 0 through hcount 31;
//     - receiver pcsc_reg[7:1]=7'b0000001.
//  2. Line 3 of field 0 (NTSC last line):
//     - pcsc = 1,0,1,0,0,0,0,1;
//     - next line is vcount=0 with field=1, F# bit=1.
//  3. pal_mode 0->1 mid-field:
//     - the current field still ends after 4 lines;
//     - the next field is 5 lines with VD=1; VL is set on vcount=4 only.
//  4. forced_clut set at hcount=3 of line 1:
//     - line 1 FC bit stays 0; line 2 FC bit=1.
//  5. enable dropped at hcount=4:
//     - pcsc=0 from the next cycle; counters read 0;
//     - re-enable restarts at line 0 with a clean burst.
//  6. reset_n asserted at hcount=2:
//     - pcsc and line_start read 0 in the same cycle;
//     - after release, the first burst matches scenario 1.

Source files
------------

// File: rtl/clio_video_pkg.sv
// ----------------------------------------------------------------------------
// clio_video_pkg
// Timing constants and the PCSC flag word layout. The CLIO transmitter and
// the MADAM receiver both import this package, so they always agree on where
// each flag sits in the serial burst.
//
// Contents:
//   PCSC_BIT_*      position of each flag within the burst (1..7)
//   PCSC_BURST_LEN  start bit plus seven flag bits
//   *_TOTAL         default NTSC/PAL line and field lengths
//   pcsc_word_t     7-bit flag word, indexed by burst position
//   pack_pcsc_word  assembles the flag word from individual flags
// ----------------------------------------------------------------------------
package clio_video_pkg;

    localparam int PCSC_BIT_VZ = 1;
    localparam int PCSC_BIT_VN = 2;
    localparam int PCSC_BIT_F  = 3;
    localparam int PCSC_BIT_FC = 4;
    localparam int PCSC_BIT_VR = 5;
    localparam int PCSC_BIT_VD = 6;
    localparam int PCSC_BIT_VL = 7;

    localparam int PCSC_BURST_LEN = 8;

    localparam int NTSC_H_TOTAL = 1588;
    localparam int NTSC_V_TOTAL = 263;
    localparam int PAL_V_TOTAL  = 313;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 9;

    // Index N of the word is burst bit N, which lands in MADAM pcsc_reg[N].
    typedef logic [PCSC_BURST_LEN-1:1] pcsc_word_t;

    function automatic pcsc_word_t pack_pcsc_word(
        input logic vz,
        input logic vn,
        input logic f,
        input logic fc,
        input logic vr,
        input logic vd,
        input logic vl
    );
        pcsc_word_t w;
        w              = '0;
        w[PCSC_BIT_VZ] = vz;
        w[PCSC_BIT_VN] = vn;
        w[PCSC_BIT_F]  = f;
        w[PCSC_BIT_FC] = fc;
        w[PCSC_BIT_VR] = vr;
        w[PCSC_BIT_VD] = vd;
        w[PCSC_BIT_VL] = vl;
        return w;
    endfunction

endpackage

// File: rtl/clio_pcsc_tx_if.sv
// ----------------------------------------------------------------------------
// clio_pcsc_tx_if
// Bundles the control inputs and the timing/PCSC outputs of clio_pcsc_tx.
//
//   enable       run timing (low holds counters at 0 and pcsc low)
//   pal_mode     VD source, applied at the next field boundary
//   forced_clut  FC source, sampled per line
//   virs_test    VR source, sampled per line
//   pcsc         serial start+flag stream
//   hcount       clock within line
//   vcount       line within field
//   field        field parity
//   line_start   one-cycle strobe coincident with the pcsc start bit
//
// master: the transmitter. slave: whoever drives the controls and watches
// the outputs.
// ----------------------------------------------------------------------------
interface clio_pcsc_tx_if;
    import clio_video_pkg::*;

    logic                enable;
    logic                pal_mode;
    logic                forced_clut;
    logic                virs_test;
    logic                pcsc;
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic                field;
    logic                line_start;

    modport master (
        input  enable, pal_mode, forced_clut, virs_test,
        output pcsc, hcount, vcount, field, line_start
    );

    modport slave (
        output enable, pal_mode, forced_clut, virs_test,
        input  pcsc, hcount, vcount, field, line_start
    );

endinterface

// File: rtl/pcsc_shifter.sv
// ----------------------------------------------------------------------------
// pcsc_shifter
// Serialises one PCSC burst: a start bit, then flag bits 1..7, LSB first.
// After the last flag, zeros shift out until the next load. This keeps pcsc
// low in the cycle before every start bit.
//
//   clk_25m   in   system clock
//   reset_n   in   async active-low reset
//   enable    in   low aborts any burst and forces pcsc low
//   load      in   the next cycle carries the start bit; word is captured
//   word      in   7-bit flag word (bit 1 goes out first)
//   pcsc      out  registered serial output
// ----------------------------------------------------------------------------
module pcsc_shifter
    import clio_video_pkg::*;
(
    input  logic       clk_25m,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       load,
    input  pcsc_word_t word,
    output logic       pcsc
);

    logic [PCSC_BURST_LEN-2:0] shift_reg;

    // Dropping enable clears the shift register as well as pcsc. A burst that
    // was cut short then leaves nothing behind for the next line.
    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            pcsc      <= 1'b0;
        end else if (!enable) begin
            shift_reg <= '0;
            pcsc      <= 1'b0;
        end else if (load) begin
            shift_reg <= word;
            pcsc      <= 1'b1;
        end else begin
            shift_reg <= {1'b0, shift_reg[PCSC_BURST_LEN-2:1]};
            pcsc      <= shift_reg[0];
        end
    end

endmodule

// File: rtl/clio_pcsc_tx.sv
// ----------------------------------------------------------------------------
// clio_pcsc_tx
// CLIO video timing generator and PCSC transmitter. Runs the horizontal and
// vertical counters. Once per line, it sends a start bit plus seven flag bits
// on pcsc so MADAM can realign its hcount and latch the line/field flags.
//
//   clk_25m   in   system clock
//   reset_n   in   async active-low reset
//   bus       master modport of clio_pcsc_tx_if (controls in; pcsc, hcount,
//             vcount, field, line_start out)
//
// Parameters: H_TOTAL clocks per line; V_TOTAL_NTSC / V_TOTAL_PAL lines per
// field for VD=0 / VD=1.
// ----------------------------------------------------------------------------
module clio_pcsc_tx
    import clio_video_pkg::*;
#(
    parameter int H_TOTAL      = NTSC_H_TOTAL,
    parameter int V_TOTAL_NTSC = NTSC_V_TOTAL,
    parameter int V_TOTAL_PAL  = PAL_V_TOTAL
) (
    input logic             clk_25m,
    input logic             reset_n,
    clio_pcsc_tx_if.master  bus
);

    localparam logic [HCOUNT_W-1:0] H_LAST      = HCOUNT_W'(H_TOTAL - 1);
    localparam logic [VCOUNT_W-1:0] V_LAST_NTSC = VCOUNT_W'(V_TOTAL_NTSC - 1);
    localparam logic [VCOUNT_W-1:0] V_LAST_PAL  = VCOUNT_W'(V_TOTAL_PAL - 1);

    logic [HCOUNT_W-1:0] hcount_q, hcount_nxt;
    logic [VCOUNT_W-1:0] vcount_q, vcount_nxt;
    logic                field_q, field_nxt;
    logic                vd_q, vd_nxt;
    logic                running_q, running_nxt;
    logic                line_start_q, line_start_nxt;
    logic [VCOUNT_W-1:0] v_last_cur, v_last_nxt;
    pcsc_word_t          flag_word;

    assign v_last_cur = vd_q   ? V_LAST_PAL : V_LAST_NTSC;
    assign v_last_nxt = vd_nxt ? V_LAST_PAL : V_LAST_NTSC;

    // The next-cycle counter state is computed one clock ahead, because pcsc
    // and line_start are registered but must line up with hcount==0. running_q
    // marks the first enabled clock. On that clock the counters stay at line 0
    // and the first start bit is launched.
    always_comb begin
        hcount_nxt     = hcount_q;
        vcount_nxt     = vcount_q;
        field_nxt      = field_q;
        vd_nxt         = vd_q;
        running_nxt    = running_q;
        line_start_nxt = 1'b0;
        if (!bus.enable) begin
            hcount_nxt  = '0;
            vcount_nxt  = '0;
            field_nxt   = 1'b0;
            vd_nxt      = bus.pal_mode;
            running_nxt = 1'b0;
        end else if (!running_q) begin
            running_nxt    = 1'b1;
            line_start_nxt = 1'b1;
        end else if (hcount_q == H_LAST) begin
            hcount_nxt     = '0;
            line_start_nxt = 1'b1;
            if (vcount_q == v_last_cur) begin
                vcount_nxt = '0;
                field_nxt  = ~field_q;
                vd_nxt     = bus.pal_mode;
            end else begin
                vcount_nxt = vcount_q + 1'b1;
            end
        end else begin
            hcount_nxt = hcount_q + 1'b1;
        end
    end

    // The flags describe the line that is about to start. FC and VR are taken
    // from the inputs on the clock that opens the line, so a mid-line change
    // shows up only in the next burst.
    assign flag_word = pack_pcsc_word(
        vcount_nxt == '0,
        vcount_nxt[0],
        field_nxt,
        bus.forced_clut,
        bus.virs_test,
        vd_nxt,
        vcount_nxt == v_last_nxt
    );

    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q     <= '0;
            vcount_q     <= '0;
            field_q      <= 1'b0;
            vd_q         <= 1'b0;
            running_q    <= 1'b0;
            line_start_q <= 1'b0;
        end else begin
            hcount_q     <= hcount_nxt;
            vcount_q     <= vcount_nxt;
            field_q      <= field_nxt;
            vd_q         <= vd_nxt;
            running_q    <= running_nxt;
            line_start_q <= line_start_nxt;
        end
    end

    pcsc_shifter u_shifter (
        .clk_25m (clk_25m),
        .reset_n (reset_n),
        .enable  (bus.enable),
        .load    (line_start_nxt),
        .word    (flag_word),
        .pcsc    (bus.pcsc)
    );

    assign bus.hcount     = hcount_q;
    assign bus.vcount     = vcount_q;
    assign bus.field      = field_q;
    assign bus.line_start = line_start_q;

endmodule

// File: tb/tb_clio_pcsc_tx.sv
// ----------------------------------------------------------------------------
// tb_clio_pcsc_tx
// Directed bench for clio_pcsc_tx with H_TOTAL=32, V_TOTAL_NTSC=4,
// V_TOTAL_PAL=5. A MADAM-style receiver model latches the flag bits into
// rx_reg[7:1]. Expected bursts are written as cycle-indexed bit vectors:
// bit k is the pcsc value at hcount==k.
// ----------------------------------------------------------------------------
module tb_clio_pcsc_tx;

    logic clk_25m;
    logic reset_n;

    int num_compared;
    int num_mismatched;

    clio_pcsc_tx_if bus ();

    clio_pcsc_tx #(
        .H_TOTAL      (32),
        .V_TOTAL_NTSC (4),
        .V_TOTAL_PAL  (5)
    ) dut (
        .clk_25m (clk_25m),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk_25m = 1'b0;
    always #20 clk_25m = ~clk_25m;

    // Receiver model: the index waits at 0 for a rising edge on pcsc. It then
    // stores the next seven samples into rx_reg[1..7].
    logic [7:1] rx_reg;
    logic [2:0] rx_idx;
    logic       rx_prev;

    always @(negedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            rx_reg  <= '0;
            rx_idx  <= 3'd0;
            rx_prev <= 1'b0;
        end else begin
            rx_prev <= bus.pcsc;
            if (rx_idx == 3'd0) begin
                if (bus.pcsc && !rx_prev)
                    rx_idx <= 3'd1;
            end else begin
                rx_reg[rx_idx] <= bus.pcsc;
                rx_idx         <= (rx_idx == 3'd7) ? 3'd0 : rx_idx + 3'd1;
            end
        end
    end

    // Safety net so a stuck design can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, mismatched=%0d", num_mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic pal, input logic fc, input logic vr);
        bus.enable      = en;
        bus.pal_mode    = pal;
        bus.forced_clut = fc;
        bus.virs_test   = vr;
    endtask

    // Advance negedge by negedge until line_start appears, within a budget.
    task automatic waitLineStart(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (bus.line_start !== 1'b1 && n < max_cycles) begin
            @(negedge clk_25m);
            n++;
        end
        checkOutput({tag, "_line_start"}, 32'(bus.line_start), 1);
    endtask

    // Called at the negedge of hcount==0; returns at the negedge of hcount==8.
    task automatic checkBurst(input string tag, input logic [7:0] exp_seq);
        checkOutput({tag, "_hcount0"}, 32'(bus.hcount), 0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s_pcsc%0d", tag, k), 32'(bus.pcsc), 32'(exp_seq[k]));
            @(negedge clk_25m);
        end
    endtask

    logic [8:0] pal_vc  [6];
    logic       pal_f   [6];
    logic [7:0] pal_seq [6];

    initial begin
        num_compared   = 0;
        num_mismatched = 0;

        // PAL field after the mid-field pal_mode change, plus the next line 0.
        pal_vc[0] = 9'd0; pal_f[0] = 1'b1; pal_seq[0] = 8'b01001011;
        pal_vc[1] = 9'd1; pal_f[1] = 1'b1; pal_seq[1] = 8'b01101101;
        pal_vc[2] = 9'd2; pal_f[2] = 1'b1; pal_seq[2] = 8'b01001001;
        pal_vc[3] = 9'd3; pal_f[3] = 1'b1; pal_seq[3] = 8'b01001101;
        pal_vc[4] = 9'd4; pal_f[4] = 1'b1; pal_seq[4] = 8'b11001001;
        pal_vc[5] = 9'd0; pal_f[5] = 1'b0; pal_seq[5] = 8'b01000011;

        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk_25m);
        checkOutput("rst_pcsc",       32'(bus.pcsc), 0);
        checkOutput("rst_line_start", 32'(bus.line_start), 0);
        checkOutput("rst_hcount",     32'(bus.hcount), 0);
        checkOutput("rst_vcount",     32'(bus.vcount), 0);
        checkOutput("rst_field",      32'(bus.field), 0);

        // Scenario 1: first line after reset release.
        reset_n = 1'b1;
        waitLineStart("s1", 4);
        checkOutput("s1_vcount", 32'(bus.vcount), 0);
        checkOutput("s1_field",  32'(bus.field), 0);
        checkBurst("s1", 8'b00000011);
        checkOutput("s1_rx", 32'(rx_reg), 32'(7'b0000001));
        for (int h = 8; h < 32; h++) begin
            checkOutput($sformatf("s1_idle_h%0d", h), 32'(bus.pcsc), 0);
            @(negedge clk_25m);
        end

        // Scenario 4: forced_clut raised at hcount 3 of line 1.
        checkOutput("s4_line_start", 32'(bus.line_start), 1);
        checkOutput("s4_vcount1", 32'(bus.vcount), 1);
        repeat (3) @(negedge clk_25m);
        checkOutput("s4_hcount3", 32'(bus.hcount), 3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk_25m);
        checkOutput("s4_rx_line1", 32'(rx_reg), 32'(7'b0000010));
        waitLineStart("s4", 40);
        checkOutput("s4_vcount2", 32'(bus.vcount), 2);
        checkBurst("s4_line2", 8'b00010001);
        checkOutput("s4_rx_line2", 32'(rx_reg), 32'(7'b0001000));

        // Scenario 3 setup: pal_mode rises mid-field; this field stays NTSC.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

        // Scenario 2: last NTSC line of field 0.
        waitLineStart("s2", 40);
        checkOutput("s2_vcount", 32'(bus.vcount), 3);
        checkOutput("s2_field",  32'(bus.field), 0);
        checkBurst("s2", 8'b10000101);
        checkOutput("s2_rx", 32'(rx_reg), 32'(7'b1000010));

        // Scenario 3: five-line PAL field; VR is raised for line 1 only.
        for (int i = 0; i < 6; i++) begin
            waitLineStart($sformatf("s3_l%0d", i), 40);
            checkOutput($sformatf("s3_l%0d_vcount", i), 32'(bus.vcount), 32'(pal_vc[i]));
            checkOutput($sformatf("s3_l%0d_field", i),  32'(bus.field), 32'(pal_f[i]));
            checkBurst($sformatf("s3_l%0d", i), pal_seq[i]);
            applyStimulus(1'b1, 1'b1, 1'b0, (i == 0) ? 1'b1 : 1'b0);
        end

        // Scenario 5: enable dropped at hcount 4 of line 1.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitLineStart("s5_pre", 40);
        repeat (4) @(negedge clk_25m);
        checkOutput("s5_hcount4", 32'(bus.hcount), 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_25m);
            checkOutput($sformatf("s5_off%0d_pcsc", c),   32'(bus.pcsc), 0);
            checkOutput($sformatf("s5_off%0d_hcount", c), 32'(bus.hcount), 0);
            checkOutput($sformatf("s5_off%0d_vcount", c), 32'(bus.vcount), 0);
            checkOutput($sformatf("s5_off%0d_field", c),  32'(bus.field), 0);
            checkOutput($sformatf("s5_off%0d_ls", c),     32'(bus.line_start), 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitLineStart("s5", 4);
        checkOutput("s5_vcount", 32'(bus.vcount), 0);
        checkOutput("s5_field",  32'(bus.field), 0);
        checkBurst("s5", 8'b00000011);
        checkOutput("s5_rx", 32'(rx_reg), 32'(7'b0000001));

        // Scenario 6: reset asserted at hcount 2 of line 1.
        waitLineStart("s6_pre", 40);
        checkOutput("s6_pre_vcount", 32'(bus.vcount), 1);
        repeat (2) @(negedge clk_25m);
        checkOutput("s6_pre_hcount", 32'(bus.hcount), 2);
        checkOutput("s6_pre_pcsc",   32'(bus.pcsc), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("s6_rst_pcsc",   32'(bus.pcsc), 0);
        checkOutput("s6_rst_ls",     32'(bus.line_start), 0);
        checkOutput("s6_rst_hcount", 32'(bus.hcount), 0);
        checkOutput("s6_rst_vcount", 32'(bus.vcount), 0);
        @(negedge clk_25m);
        reset_n = 1'b1;
        waitLineStart("s6", 4);
        checkOutput("s6_vcount", 32'(bus.vcount), 0);
        checkBurst("s6", 8'b00000011);
        checkOutput("s6_rx", 32'(rx_reg), 32'(7'b0000001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
